// File: rtl/vga_system_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// vga_system_irq_ctrl_if
//
// Avalon-MM slave bus bundle for the interrupt controller.
//
// Signals:
//   address    [2:0]   word address
//   chipselect         slave select
//   write_n            active-low write strobe
//   writedata  [15:0]  write data
//   readdata   [15:0]  registered read data (driven by the slave)
//
// Modports:
//   master  drives address/chipselect/write_n/writedata, samples readdata
//   slave   samples address/chipselect/write_n/writedata, drives readdata
// ---------------------------------------------------------------------------
interface vga_system_irq_ctrl_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/vga_system_irq_ctrl.sv
// ---------------------------------------------------------------------------
// vga_system_irq_ctrl
//
// Interrupt aggregator for up to 16 sources with an Avalon-MM register file.
// Each source can be captured on a rising edge (sticky pending bit, cleared by
// write-1-to-clear) or passed through as a level (pending follows the sampled
// input one clock later). Masked pending bits are ORed onto irq_out.
//
// Parameters:
//   NUM_SRC   number of interrupt sources, 1..16 (default 8)
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       Avalon-MM slave (vga_system_irq_ctrl_if.slave)
//   irq_in    [NUM_SRC-1:0] source requests
//   irq_out   aggregated interrupt, OR(PENDING & MASK)
//
// Register map (16-bit words, bits at and above NUM_SRC read 0):
//   0 PENDING   read pending; write 1 clears edge-mode bits
//   1 MASK      R/W enable per source
//   2 EDGE_SEL  R/W, 1 = rising-edge capture, 0 = level (resets all-ones)
//   3 ACTIVE    RO, PENDING & MASK
//   4 ID        RO, bit15 valid, bits 3:0 lowest active index
//   5 SWTRIG    write 1 sets pending on edge-mode bits; reads 0
//   6 COUNT     accepted-event counter, saturates at 0xFFFF; any write clears
//   7 -         reads 0, writes ignored
//
// Build option:
//   VGA_SYSTEM_IRQC_SYNC_EN  when defined, irq_in passes through a 2-flop
//                            synchronizer (one extra clock of latency);
//                            otherwise a single sample flop is used.
// ---------------------------------------------------------------------------
module vga_system_irq_ctrl #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  vga_system_irq_ctrl_if.slave  bus,
  input  logic [NUM_SRC-1:0]    irq_in,
  output logic                  irq_out
);

  typedef logic [NUM_SRC-1:0] src_t;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_EDGESEL = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_ID      = 3'd4;
  localparam logic [2:0] ADDR_SWTRIG  = 3'd5;
  localparam logic [2:0] ADDR_COUNT   = 3'd6;

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic wr;
  logic wr_pending;
  logic wr_mask;
  logic wr_edgesel;
  logic wr_swtrig;
  logic wr_count;
  src_t wdata_src;
  logic unused_wdata;

  assign wr         = bus.chipselect & ~bus.write_n;
  assign wr_pending = wr & (bus.address == ADDR_PENDING);
  assign wr_mask    = wr & (bus.address == ADDR_MASK);
  assign wr_edgesel = wr & (bus.address == ADDR_EDGESEL);
  assign wr_swtrig  = wr & (bus.address == ADDR_SWTRIG);
  assign wr_count   = wr & (bus.address == ADDR_COUNT);
  assign wdata_src  = bus.writedata[NUM_SRC-1:0];

  // Upper data bits are meaningless for narrow configurations and COUNT
  // ignores the data entirely.
  assign unused_wdata = ^bus.writedata;

  // -------------------------------------------------------------------------
  // Input sampling
  // -------------------------------------------------------------------------
  src_t s_q;       // sampled (optionally synchronized) irq_in
  src_t s_prev_q;  // s_q one clock earlier, for rising-edge detection

`ifdef VGA_SYSTEM_IRQC_SYNC_EN
  src_t meta_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      s_q    <= '0;
    end else begin
      meta_q <= irq_in;
      s_q    <= meta_q;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q <= '0;
    end else begin
      s_q <= irq_in;
    end
  end
`endif

  // s_prev_q tracks s_q regardless of mode, so switching a source from level
  // to edge starts detection from the current input value and does not
  // fabricate an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_prev_q <= '0;
    end else begin
      s_prev_q <= s_q;
    end
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  src_t mask_q;
  src_t edge_sel_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      edge_sel_q <= '1;
    end else begin
      if (wr_mask) begin
        mask_q <= wdata_src;
      end
      if (wr_edgesel) begin
        edge_sel_q <= wdata_src;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pending
  // -------------------------------------------------------------------------
  src_t pending_q;
  src_t pending_d;
  src_t edge_set;
  src_t sw_set;
  src_t w1c;
  src_t set_evt;

  always_comb begin
    edge_set = s_q & ~s_prev_q & edge_sel_q;
    sw_set   = (wr_swtrig ? wdata_src : '0) & edge_sel_q;
    w1c      = (wr_pending ? wdata_src : '0) & edge_sel_q;
    set_evt  = edge_set | sw_set;
    // Edge-mode bits: set beats clear in the same cycle.
    // Level-mode bits: follow the sample one clock later, immune to W1C/SWTRIG.
    pending_d = (edge_sel_q & ((pending_q & ~w1c) | set_evt))
              | (~edge_sel_q & s_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // -------------------------------------------------------------------------
  // Accepted-event counter
  // -------------------------------------------------------------------------
  // One count per clock in which any edge-mode bit receives a set event
  // (hardware edge or SWTRIG), even if that bit was already pending.
  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (wr_count) begin
      count_d = '0;
    end else if ((|set_evt) && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // -------------------------------------------------------------------------
  // Active, aggregate interrupt and ID encoder
  // -------------------------------------------------------------------------
  src_t       active;
  logic       id_valid;
  logic [3:0] id_idx;

  assign active  = pending_q & mask_q;
  assign irq_out = |active;

  // Scan high to low so the lowest active index is the last one written.
  always_comb begin
    id_valid = 1'b0;
    id_idx   = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (active[i]) begin
        id_valid = 1'b1;
        id_idx   = 4'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path: mux captured every clock, independent of chipselect
  // -------------------------------------------------------------------------
  logic [15:0] rdata_d;
  logic [15:0] rdata_q;

  always_comb begin
    rdata_d = '0;
    case (bus.address)
      ADDR_PENDING: rdata_d = 16'(pending_q);
      ADDR_MASK:    rdata_d = 16'(mask_q);
      ADDR_EDGESEL: rdata_d = 16'(edge_sel_q);
      ADDR_ACTIVE:  rdata_d = 16'(active);
      ADDR_ID:      rdata_d = id_valid ? {1'b1, 11'd0, id_idx} : 16'd0;
      ADDR_COUNT:   rdata_d = count_q;
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_vga_system_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_system_irq_ctrl
//
// Directed self-checking bench for vga_system_irq_ctrl (NUM_SRC = 8).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_vga_system_irq_ctrl;

`ifdef VGA_SYSTEM_IRQC_SYNC_EN
  localparam int LAT = 3;  // rising edges from irq_in change to pending
`else
  localparam int LAT = 2;
`endif

  logic       clk;
  logic       reset_n;
  logic [7:0] irq_in;
  logic       irq_out;

  int checks;
  int failures;

  vga_system_irq_ctrl_if bus ();

  vga_system_irq_ctrl #(
    .NUM_SRC (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq_in  (irq_in),
    .irq_out (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    reset_n        = 1'b0;
    irq_in         = '0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq_out got=%b exp=0", irq_out);
    end
    checks++;
    if (bus.readdata !== 16'h0000) begin
      failures++;
      $display("FAIL reset_readdata got=%h exp=0000", bus.readdata);
    end
    reset_n = 1'b1;
    rd(3'd2, d);
    checks++;
    if (d !== 16'h00FF) begin
      failures++;
      $display("FAIL reset_edge_sel got=%h exp=00ff", d);
    end
    rd(3'd0, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL reset_pending got=%h exp=0000", d);
    end
    rd(3'd1, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mask got=%h exp=0000", d);
    end
    rd(3'd6, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL reset_count got=%h exp=0000", d);
    end
  endtask

  task automatic test_edge_basic();
    logic [15:0] d;
    wr(3'd1, 16'h0001);
    irq_in[0] = 1'b1;
    @(negedge clk);
    irq_in[0] = 1'b0;
    repeat (LAT - 2) @(negedge clk);
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL edge_early got=%b exp=0", irq_out);
    end
    @(negedge clk);
    checks++;
    if (irq_out !== 1'b1) begin
      failures++;
      $display("FAIL edge_latency got=%b exp=1", irq_out);
    end
    rd(3'd0, d);
    checks++;
    if (d !== 16'h0001) begin
      failures++;
      $display("FAIL edge_pending got=%h exp=0001", d);
    end
    rd(3'd6, d);
    checks++;
    if (d !== 16'h0001) begin
      failures++;
      $display("FAIL edge_count got=%h exp=0001", d);
    end
    wr(3'd0, 16'h0001);
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL edge_w1c_irq got=%b exp=0", irq_out);
    end
    wr(3'd6, 16'h0000);
    rd(3'd6, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL count_clear got=%h exp=0000", d);
    end
  endtask

  task automatic test_id();
    logic [15:0] d;
    wr(3'd1, 16'h0028);
    irq_in = 8'h28;
    @(negedge clk);
    irq_in = 8'h00;
    repeat (LAT) @(negedge clk);
    rd(3'd4, d);
    checks++;
    if (d !== 16'h8003) begin
      failures++;
      $display("FAIL id_lowest got=%h exp=8003", d);
    end
    rd(3'd3, d);
    checks++;
    if (d !== 16'h0028) begin
      failures++;
      $display("FAIL id_active got=%h exp=0028", d);
    end
    wr(3'd0, 16'h0008);
    rd(3'd4, d);
    checks++;
    if (d !== 16'h8005) begin
      failures++;
      $display("FAIL id_next got=%h exp=8005", d);
    end
    wr(3'd0, 16'h0020);
    rd(3'd4, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL id_none got=%h exp=0000", d);
    end
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL id_irq_out got=%b exp=0", irq_out);
    end
    // Two bits in one cycle count once.
    rd(3'd6, d);
    checks++;
    if (d !== 16'h0001) begin
      failures++;
      $display("FAIL id_count got=%h exp=0001", d);
    end
    wr(3'd6, 16'h0000);
  endtask

  task automatic test_level();
    logic [15:0] d;
    logic        exp;
    wr(3'd2, 16'h00FE);
    wr(3'd1, 16'h0001);
    irq_in[0] = 1'b1;
    for (int n = 1; n <= LAT + 11; n++) begin
      @(negedge clk);
      exp = (n >= LAT) && (n < LAT + 10);
      checks++;
      if (irq_out !== exp) begin
        failures++;
        $display("FAIL level_cycle%0d got=%b exp=%b", n, irq_out, exp);
      end
      if (n == 10) irq_in[0] = 1'b0;
      if (n == 3) begin
        bus.address    = 3'd0;
        bus.writedata  = 16'h0001;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
      end
      if (n == 4) begin
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
      end
    end
    rd(3'd6, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL level_count got=%h exp=0000", d);
    end
  endtask

  task automatic test_mode_switch();
    logic [15:0] d;
    irq_in[0] = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    wr(3'd2, 16'h00FF);
    repeat (3) @(negedge clk);
    irq_in[0] = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    rd(3'd0, d);
    checks++;
    if (d !== 16'h0001) begin
      failures++;
      $display("FAIL switch_keep got=%h exp=0001", d);
    end
    rd(3'd6, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL switch_no_edge got=%h exp=0000", d);
    end
    wr(3'd0, 16'h0001);
    rd(3'd0, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL switch_w1c got=%h exp=0000", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_rd [4];
    exp_rd[0] = 16'h0001;  // MASK before the write lands
    exp_rd[1] = 16'h00A5;  // MASK after
    exp_rd[2] = 16'h00FF;  // EDGE_SEL
    exp_rd[3] = 16'h0000;  // addr 7
    @(negedge clk);
    bus.address    = 3'd1;
    bus.writedata  = 16'h00A5;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.readdata !== exp_rd[k]) begin
        failures++;
        $display("FAIL b2b_read%0d got=%h exp=%h", k, bus.readdata, exp_rd[k]);
      end
      bus.write_n = 1'b1;
      if (k == 0) bus.address = 3'd1;
      if (k == 1) bus.address = 3'd2;
      if (k == 2) bus.address = 3'd7;
    end
    bus.chipselect = 1'b0;
    wr(3'd1, 16'h0000);
  endtask

  task automatic test_priority();
    logic [15:0] d;
    wr(3'd5, 16'h0004);
    irq_in[2] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    bus.address    = 3'd0;
    bus.writedata  = 16'h0004;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    irq_in[2]      = 1'b0;
    rd(3'd0, d);
    checks++;
    if (d !== 16'h0004) begin
      failures++;
      $display("FAIL set_beats_clear got=%h exp=0004", d);
    end
    rd(3'd6, d);
    checks++;
    if (d !== 16'h0002) begin
      failures++;
      $display("FAIL prio_count got=%h exp=0002", d);
    end
    wr(3'd0, 16'h0004);
    irq_in[2] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    bus.address    = 3'd6;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    irq_in[2]      = 1'b0;
    rd(3'd6, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL count_clear_wins got=%h exp=0000", d);
    end
    rd(3'd0, d);
    checks++;
    if (d !== 16'h0004) begin
      failures++;
      $display("FAIL edge_during_clear got=%h exp=0004", d);
    end
    wr(3'd0, 16'h00FF);
    wr(3'd5, 16'h0010);
    rd(3'd0, d);
    checks++;
    if (d !== 16'h0010) begin
      failures++;
      $display("FAIL swtrig_set got=%h exp=0010", d);
    end
    rd(3'd5, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL swtrig_read got=%h exp=0000", d);
    end
    wr(3'd0, 16'h00FF);
  endtask

  task automatic test_saturate();
    logic [15:0] d;
    wr(3'd6, 16'h0000);
    @(negedge clk);
    bus.address    = 3'd5;
    bus.writedata  = 16'h0001;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    repeat (65534) @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    rd(3'd6, d);
    checks++;
    if (d !== 16'hFFFE) begin
      failures++;
      $display("FAIL count_near_max got=%h exp=fffe", d);
    end
    @(negedge clk);
    bus.address    = 3'd5;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    repeat (3) @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    rd(3'd6, d);
    checks++;
    if (d !== 16'hFFFF) begin
      failures++;
      $display("FAIL count_saturate got=%h exp=ffff", d);
    end
    wr(3'd6, 16'h0000);
    wr(3'd0, 16'h00FF);
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    wr(3'd1, 16'h0001);
    wr(3'd5, 16'h0001);
    checks++;
    if (irq_out !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre_irq got=%b exp=1", irq_out);
    end
    irq_in[1] = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL mid_async_drop got=%b exp=0", irq_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rd(3'd1, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL mid_mask got=%h exp=0000", d);
    end
    rd(3'd2, d);
    checks++;
    if (d !== 16'h00FF) begin
      failures++;
      $display("FAIL mid_edge_sel got=%h exp=00ff", d);
    end
    rd(3'd6, d);
    checks++;
    if (d !== 16'h0001) begin
      failures++;
      $display("FAIL mid_count got=%h exp=0001", d);
    end
    // irq_in[1] held through release appears as a fresh edge.
    rd(3'd0, d);
    checks++;
    if (d !== 16'h0002) begin
      failures++;
      $display("FAIL mid_held_edge got=%h exp=0002", d);
    end
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL mid_irq_masked got=%b exp=0", irq_out);
    end
    irq_in[1] = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_edge_basic();
    test_id();
    test_level();
    test_mode_switch();
    test_back_to_back();
    test_priority();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
